// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the data-memory controller.
// Holds state encoding, word geometry and default sizing.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int WORD_BYTES          = 4;
    localparam int DEFAULT_DEPTH_WORDS = 64;
    localparam int DEFAULT_LATENCY     = 2;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage data-memory bus between the EX/MEM register and the controller.
// The pipeline side is master, the controller is slave.
interface dmem_if;

    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_WriteData;
    logic [31:0] MEM_ReadData;
    logic        Stall;
    logic        MisalignErr;

    modport master (
        output MEM_MemRead,
        output MEM_MemWrite,
        output MEM_Address,
        output MEM_WriteData,
        input  MEM_ReadData,
        input  Stall,
        input  MisalignErr
    );

    modport slave (
        input  MEM_MemRead,
        input  MEM_MemWrite,
        input  MEM_Address,
        input  MEM_WriteData,
        output MEM_ReadData,
        output Stall,
        output MisalignErr
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one combinational read port, one synchronous write port.
// Contents start at zero and are never touched by reset.
module dmem_array
    import pipeline_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage.
// Stalls the pipeline for LATENCY-1 cycles per aligned access.
module dmem_ctrl
    import pipeline_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LOAD  = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic             aligned;
    logic             done;
    logic             stall;
    logic             misalign;
    logic             we;
    logic             rd_only;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rdata;
    logic             unused_addr;

    assign req     = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign rd_only = bus.MEM_MemRead & ~bus.MEM_MemWrite;
    assign aligned = (bus.MEM_Address[OFF_W-1:0] == '0);
    assign idx     = bus.MEM_Address[IDX_W+OFF_W-1:OFF_W];

    // High address bits wrap away by design.
    assign unused_addr = ^bus.MEM_Address[31:IDX_W+OFF_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        misalign = 1'b1;
                    end else if (LATENCY == 1) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates every output so an in-flight access dies instantly.
    assign we              = done & bus.MEM_MemWrite & ~reset;
    assign bus.Stall       = stall & ~reset;
    assign bus.MisalignErr = misalign & ~reset;
    assign bus.MEM_ReadData =
        (done & rd_only & ~reset) ? rdata : '0;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (idx),
        .wdata_i (bus.MEM_WriteData),
        .rdata_o (rdata)
    );

endmodule
